// File: rtl/socket_out_buffer_if.sv
// Bundle of producer, consumer and status signals around socket_out_buffer.
// The buffer side uses the slave modport; the driving environment uses master.
interface socket_out_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_dv;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] data;
  logic                  dv;
  logic                  full;
  logic                  rd_en;
  logic [LW-1:0]         level;
  logic                  frame_end;
  logic                  ovf;
  logic                  udf;
  logic                  clr_err;

  modport slave (
    input  in_data, in_dv, rd_en, clr_err,
    output in_full, data, dv, full, level, frame_end, ovf, udf
  );

  modport master (
    output in_data, in_dv, rd_en, clr_err,
    input  in_full, data, dv, full, level, frame_end, ovf, udf
  );
endinterface

// File: rtl/socket_out_buffer.sv
// First-word-fall-through circular output buffer with frame accounting and
// sticky overflow/underflow flags.
module socket_out_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FRAME_LEN  = 8
) (
  input logic                clk,
  input logic                rst,
  socket_out_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  frame_end_q, frame_end_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  state_e                state_q, state_d;

  logic dv_int;
  logic full_int;
  logic wr_acc;
  logic rd_acc;
  logic frame_wrap;

  // Full/empty decisions come from the pre-edge state, so a simultaneous read
  // never frees a slot for a write on the same edge.
  assign dv_int     = (state_q != StEmpty);
  assign full_int   = (state_q == StFull);
  assign wr_acc     = bus.in_dv & ~full_int;
  assign rd_acc     = bus.rd_en & dv_int;
  assign frame_wrap = wr_acc && (frame_cnt_q == FW'(FRAME_LEN - 1));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    frame_end_d = frame_wrap;

    if (wr_acc) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Error flags: a set event on the same edge as clr_err leaves the flag high.
  always_comb begin
    ovf_d = bus.clr_err ? 1'b0 : ovf_q;
    udf_d = bus.clr_err ? 1'b0 : udf_q;
    if (bus.in_dv && full_int) begin
      ovf_d = 1'b1;
    end
    if (bus.rd_en && !dv_int) begin
      udf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (wr_acc) begin
          state_d = StPartial;
        end
      end
      StPartial: begin
        if (wr_acc && !rd_acc && (level_q == LW'(DEPTH - 1))) begin
          state_d = StFull;
        end else if (rd_acc && !wr_acc && (level_q == LW'(1))) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (rd_acc) begin
          state_d = StPartial;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      frame_end_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      frame_end_q <= frame_end_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Storage is not reset; a write slipping in during reset lands in a slot the
  // reset pointers already treat as free.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.data      = mem_q[rd_ptr_q];
  assign bus.dv        = dv_int;
  assign bus.full      = full_int;
  assign bus.in_full   = full_int;
  assign bus.level     = level_q;
  assign bus.frame_end = frame_end_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;
endmodule

// File: tb/tb_socket_out_buffer.sv
// Scoreboard bench for socket_out_buffer: stimulus queues expected words,
// a negedge monitor checks every popped word in order.
module tb_socket_out_buffer;
  localparam int unsigned DW        = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned FRAME_LEN = 8;

  logic clk = 1'b0;
  logic rst;

  socket_out_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  socket_out_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens on the next edge whenever dv and rd_en are both high.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.dv === 1'b1 && bus.rd_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", bus.data);
      end else begin
        check("pop_data", bus.data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst         = 1'b1;
    bus.in_data = '0;
    bus.in_dv   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    #1;
    check("rst_dv", bus.dv, 0);
    check("rst_full", bus.full, 0);
    check("rst_in_full", bus.in_full, 0);
    check("rst_level", bus.level, 0);
    check("rst_flags", {bus.ovf, bus.udf, bus.frame_end}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, fall-through latency 1, then pop.
    bus.in_data = 8'h11; bus.in_dv = 1'b1; exp_q.push_back(8'h11);
    step();
    bus.in_dv = 1'b0;
    check("single_dv", bus.dv, 1);
    check("single_data", bus.data, 8'h11);
    check("single_level", bus.level, 1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("single_empty_dv", bus.dv, 0);
    check("single_empty_level", bus.level, 0);
    check("single_udf", bus.udf, 0);

    // Fill to DEPTH, then a dropped write.
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'(i); bus.in_dv = 1'b1; exp_q.push_back(8'(i));
      step();
      if (i == 14) begin
        check("fill15_full", bus.full, 0);
        check("fill15_level", bus.level, 15);
      end
    end
    check("fill_full", bus.full, 1);
    check("fill_in_full", bus.in_full, 1);
    check("fill_level", bus.level, 16);
    check("fill_ovf_clear", bus.ovf, 0);
    bus.in_data = 8'hAA;
    step();
    bus.in_dv = 1'b0;
    check("drop_ovf", bus.ovf, 1);
    check("drop_level", bus.level, 16);

    // Clear, then simultaneous read+write while full.
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("clr_ovf", bus.ovf, 0);
    bus.in_data = 8'hBB; bus.in_dv = 1'b1; bus.rd_en = 1'b1;
    step();
    bus.in_dv = 1'b0; bus.rd_en = 1'b0;
    check("fullrw_level", bus.level, 15);
    check("fullrw_ovf", bus.ovf, 1);
    check("fullrw_full", bus.full, 0);
    check("fullrw_head", bus.data, 8'h01);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("clr_ovf2", bus.ovf, 0);
    bus.rd_en = 1'b1;
    repeat (15) step();
    bus.rd_en = 1'b0;
    check("drain_dv", bus.dv, 0);
    check("drain_level", bus.level, 0);
    check("drain_udf", bus.udf, 0);
    check("drain_queue", exp_q.size(), 0);

    // Underflow cases.
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("udf_set", bus.udf, 1);
    check("udf_level", bus.level, 0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("udf_clr", bus.udf, 0);
    bus.in_data = 8'h5A; bus.in_dv = 1'b1; bus.rd_en = 1'b1; exp_q.push_back(8'h5A);
    step();
    bus.in_dv = 1'b0; bus.rd_en = 1'b0;
    check("udfw_udf", bus.udf, 1);
    check("udfw_dv", bus.dv, 1);
    check("udfw_level", bus.level, 1);
    check("udfw_data", bus.data, 8'h5A);
    bus.rd_en = 1'b1;
    step();
    bus.clr_err = 1'b1;
    step();
    bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    check("udf_set_wins", bus.udf, 1);
    check("udf_set_wins_level", bus.level, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_udf", bus.udf, 0);

    // Streaming 40 words across pointer wrap with frame accounting.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      bus.in_data = 8'(8'h40 + i); bus.in_dv = 1'b1; bus.rd_en = (i > 0);
      exp_q.push_back(8'(8'h40 + i));
      step();
      check("stream_frame_end", bus.frame_end, ((i + 1) % 8 == 0));
      if (bus.frame_end === 1'b1) pulses++;
      if (i == 39) check("stream_level", bus.level, 1);
    end
    bus.in_dv = 1'b0; bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("stream_frame_end_tail", bus.frame_end, 0);
    check("stream_pulses", pulses, 5);
    check("stream_level_end", bus.level, 0);
    check("stream_udf", bus.udf, 0);
    check("stream_queue", exp_q.size(), 0);

    // Asynchronous reset mid-cycle with 7 words held.
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_data = 8'(8'h60 + i); bus.in_dv = 1'b1;
      step();
    end
    bus.in_dv = 1'b0;
    check("pre_rst_level", bus.level, 7);
    check("pre_rst_udf", bus.udf, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_dv", bus.dv, 0);
    check("arst_full", bus.full, 0);
    check("arst_level", bus.level, 0);
    check("arst_flags", {bus.ovf, bus.udf, bus.frame_end}, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(8'h77 + i); bus.in_dv = 1'b1; exp_q.push_back(8'(8'h77 + i));
      step();
      if (i == 0) begin
        check("post_rst_dv", bus.dv, 1);
        check("post_rst_data", bus.data, 8'h77);
        check("post_rst_level", bus.level, 1);
      end
      check("post_rst_frame_end", bus.frame_end, (i == 7));
    end
    bus.in_dv = 1'b0; bus.rd_en = 1'b1;
    repeat (8) step();
    bus.rd_en = 1'b0;
    check("final_level", bus.level, 0);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
